// File: rtl/uart_pack_ack_tx.sv
// Echoes each received field set back to the host as a 9-byte 8N1 ack packet:
// HEAD0, HEAD1, A, B[15:8], B[7:0], C[15:8], C[7:0], D, CHK (sum of the six field bytes).
module uart_pack_ack_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200,
  parameter logic [7:0]  HEAD0    = 8'h55,
  parameter logic [7:0]  HEAD1    = 8'hAA
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        recv_done,
  input  logic [7:0]  dataA,
  input  logic [15:0] dataB,
  input  logic [15:0] dataC,
  input  logic [7:0]  dataD,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        ack_done
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CntW    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BPS_CNT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [3:0]      byte_idx_q;
  logic [7:0]      a_q, d_q, chk_q;
  logic [15:0]     b_q, c_q;
  logic            txd_q, busy_q, ack_q;

  logic [7:0] chk_in;
  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;
  logic       bit_end;

  // 8-bit wrap is intentional: the checksum is the sum mod 256.
  always_comb begin
    chk_in = dataA + dataB[15:8] + dataB[7:0] + dataC[15:8] + dataC[7:0] + dataD;
  end

  always_comb begin
    cur_byte = HEAD0;
    case (byte_idx_q)
      4'd0:    cur_byte = HEAD0;
      4'd1:    cur_byte = HEAD1;
      4'd2:    cur_byte = a_q;
      4'd3:    cur_byte = b_q[15:8];
      4'd4:    cur_byte = b_q[7:0];
      4'd5:    cur_byte = c_q[15:8];
      4'd6:    cur_byte = c_q[7:0];
      4'd7:    cur_byte = d_q;
      4'd8:    cur_byte = chk_q;
      default: cur_byte = HEAD0;
    endcase
  end

  assign bit_nxt = bit_idx_q + 3'd1;
  assign bit_end = (cnt_q == CntMax);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      chk_q      <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          // A pulse coinciding with ack_done is dropped; only a later IDLE sample starts a packet.
          if (recv_done && !ack_q) begin
            a_q        <= dataA;
            b_q        <= dataB;
            c_q        <= dataC;
            d_q        <= dataD;
            chk_q      <= chk_in;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= cur_byte[0];
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_nxt;
              txd_q     <= cur_byte[bit_nxt];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_idx_q < 4'd8) begin
              byte_idx_q <= byte_idx_q + 4'd1;
              txd_q      <= 1'b0;
              state_q    <= StStart;
            end else begin
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign ack_done = ack_q;

endmodule
